cla_step_counter: RTL and testbench
===================================

Name: cla_step_counter

Overview:
Parametrised up/down step counter whose next-state adder is a grouped carry-lookahead adder. It generalises the team's fixed 5-bit CLA into a WIDTH-bit, group-partitioned CLA that drives a registered counter. The counter supports load, programmable step, wrap or saturate mode, and overflow/underflow flags. It sits in the counter subsystem as the standard programmable counter primitive.

Parameters:
WIDTH, 5, counter and adder width in bits (>=2)
GROUP, 4, CLA group size: a lookahead block of GROUP bits, with group carries rippled between blocks; the last group may be partial
RST_VAL, 0, count value after reset (WIDTH bits)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
up  input  1  1 = add step, 0 = subtract step
step  input  WIDTH  increment magnitude, unsigned
sat_mode  input  1  1 = saturate at limits, 0 = wrap modulo 2^WIDTH
count  output  WIDTH  registered count
ovf  output  1  registered, 1-cycle pulse: the add carried out of the MSB
unf  output  1  registered, 1-cycle pulse: the subtract borrowed
tc  output  1  combinational terminal count: count==all-ones when up=1, count==0 when up=0

Behaviour:
- Reset (async, rst_n=0): count=RST_VAL, ovf=0, unf=0 immediately, independent of clk. Release is synchronous to the next rising edge; the first update happens on the first edge with rst_n=1.
- Adder: per-bit P=a^b and G=a&b. Within a group, carries use full lookahead: c[i+1]=G[i]|P[i]&c[i], expanded to sum-of-products from the group carry-in. Group carry-out feeds the next group. sum[i]=P[i]^c[i].
- Add path: a=count, b=step, cin=0. Subtract path: b=~step, cin=1. raw_cout is the carry out of the MSB.
- Per rising edge, in priority order:
  1. load=1: count<=load_val; ovf<=0; unf<=0. en is ignored.
  2. en=1, up=1: if raw_cout=1, set ovf<=1 and count<=sum in wrap mode, or all-ones in sat mode. Otherwise count<=sum.
  3. en=1, up=0: borrow = ~raw_cout. If borrow=1, set unf<=1 and count<=sum in wrap mode, or 0 in sat mode. Otherwise count<=sum.
  4. en=0: count holds; ovf<=0; unf<=0.
- Latency: count reflects the operation one cycle after the edge that samples the controls. ovf and unf are valid in the same cycle as the updated count.
- step=0 with en=1: count is unchanged and no flag is raised. Subtracting 0 gives raw_cout=1, so no borrow.
- Saturation at a limit: count stays at the limit. The flag re-asserts on every enabled cycle that would exceed the limit.
- All inputs are sampled only at the clock edge. There are no combinational paths to count, ovf or unf.
- tc is a function only of count and up.
- Reset asserted mid-count: outputs clear immediately. Any load pending in that cycle is discarded.
- The WIDTH not divisible by GROUP case (e.g. 5/4) must produce identical sums to a behavioural a+b.

Test Plan:
1. Reset: WIDTH=5, rst_n=0 asynchronously mid-cycle -> count=0, ovf=0, unf=0 before the next edge. Release, en=0 for 3 cycles -> count stays 0.
2. Wrap up: load 29, then up=1, step=1, sat_mode=0, en=1 for 4 cycles -> count 30, 31, 0 (ovf=1 this cycle only), 1. tc=1 while count=31.
3. Saturate down: load 5, up=0, step=7, sat_mode=1, en=1 -> count=0, unf=1. Next cycle -> count=0, unf=1 again. Then en=0 -> unf=0.
4. Load priority: load=1, load_val=18 with en=1, up=1, step=3 -> count=18, no flag. Next cycle with load=0 -> count=21.
5. Wrap down with carry chain across groups: WIDTH=9, GROUP=4, count=0x100, up=0, step=1 -> 0x0FF, unf=0. Then load 0, subtract 1, wrap mode -> 0x1FF, unf=1.
6. Random: 10k cycles, random controls, WIDTH∈{5,8,13}, GROUP∈{2,4} -> count, ovf and unf match a behavioural model every cycle.

Source files
------------

// File: rtl/cla_step_counter.sv
// rtl/cla_step_counter.sv - up/down step counter with a grouped carry-lookahead next-state adder
//
// cla_cpa_group : one lookahead block of W bits. Carries are flattened sum-of-products from cin.
//    a_i, b_i   operands          cin_i  group carry-in
//    sum_o      W-bit sum         cout_o group carry-out
// cla_cpa       : WIDTH-bit adder built from GROUP-bit blocks. Group carries ripple between blocks.
//                 The last block is narrower when WIDTH is not a multiple of GROUP.
//    a_i, b_i, cin_i -> sum_o, cout_o
// cla_step_counter : registered counter with load, step, wrap/saturate and flags.
//    clk, rst_n         clock (rising edge) and asynchronous active-low reset
//    en, load, load_val count enable, synchronous load strobe and load value
//    up, step           direction and unsigned step magnitude
//    sat_mode           1 = clamp at 0 / all-ones, 0 = wrap modulo 2^WIDTH
//    count, ovf, unf    registered count and one-cycle overflow / underflow pulses
//    tc                 combinational terminal count for the current direction

module cla_cpa_group #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   logic [W-1:0] p;
   logic [W-1:0] g;
   logic [W:0]   c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   // c[i+1] = G[i] | P[i]G[i-1] | ... | P[i]..P[0]cin, written out per bit so
   // no carry depends on another carry inside the block.
   always_comb begin
      logic acc;
      logic prod;
      c    = '0;
      c[0] = cin_i;
      for (int i = 0; i < W; i++) begin
         prod = cin_i;
         for (int k = 0; k <= i; k++) begin
            prod = prod & p[k];
         end
         acc = prod;
         for (int j = 0; j <= i; j++) begin
            prod = g[j];
            for (int k = j + 1; k <= i; k++) begin
               prod = prod & p[k];
            end
            acc = acc | prod;
         end
         c[i+1] = acc;
      end
   end

   assign sum_o  = p ^ c[W-1:0];
   assign cout_o = c[W];

endmodule

module cla_cpa #(
   parameter int WIDTH = 5,
   parameter int GROUP = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int NG = (WIDTH + GROUP - 1) / GROUP;

   logic [NG:0] gc;

   assign gc[0] = cin_i;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int LO = gi * GROUP;
      localparam int GW = ((WIDTH - LO) < GROUP) ? (WIDTH - LO) : GROUP;

      cla_cpa_group #(.W(GW)) u_grp (
         .a_i    (a_i[LO+GW-1:LO]),
         .b_i    (b_i[LO+GW-1:LO]),
         .cin_i  (gc[gi]),
         .sum_o  (sum_o[LO+GW-1:LO]),
         .cout_o (gc[gi+1])
      );
   end

   assign cout_o = gc[NG];

endmodule

module cla_step_counter #(
   parameter int               WIDTH   = 5,
   parameter int               GROUP   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic [WIDTH-1:0] step,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             unf,
   output logic             tc
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] sum;
   logic             raw_cout;

   // Subtraction is count + ~step + 1, so a carry-out of 0 means a borrow.
   assign add_b   = up ? step : ~step;
   assign add_cin = ~up;

   cla_cpa #(.WIDTH(WIDTH), .GROUP(GROUP)) u_add (
      .a_i    (count_q),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (sum),
      .cout_o (raw_cout)
   );

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         if (up) begin
            if (raw_cout) begin
               ovf_d   = 1'b1;
               count_d = sat_mode ? '1 : sum;
            end else begin
               count_d = sum;
            end
         end else begin
            if (!raw_cout) begin
               unf_d   = 1'b1;
               count_d = sat_mode ? '0 : sum;
            end else begin
               count_d = sum;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= RST_VAL;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;
   assign tc    = up ? (&count_q) : ~(|count_q);

endmodule

// File: tb/tb_cla_step_counter.sv
// tb/tb_cla_step_counter.sv - self-checking bench for cla_step_counter over several WIDTH/GROUP sizes

module tb_cla_step_counter;

   localparam int NCFG = 6;
   localparam int CFG_W [NCFG] = '{5, 9, 8, 13, 13, 5};
   localparam int CFG_G [NCFG] = '{4, 4, 2, 4, 2, 2};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [12:0] load_val = '0;
   logic        up = 1'b0;
   logic [12:0] step = '0;
   logic        sat_mode = 1'b0;

   logic [12:0] cnt_a [NCFG];
   logic        ovf_a [NCFG];
   logic        unf_a [NCFG];
   logic        tc_a  [NCFG];

   int m_cnt [NCFG];
   int m_ovf [NCFG];
   int m_unf [NCFG];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
      localparam int W = CFG_W[gi];
      logic [W-1:0] c;
      logic         o, u, t;

      cla_step_counter #(.WIDTH(W), .GROUP(CFG_G[gi])) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en),
         .load     (load),
         .load_val (load_val[W-1:0]),
         .up       (up),
         .step     (step[W-1:0]),
         .sat_mode (sat_mode),
         .count    (c),
         .ovf      (o),
         .unf      (u),
         .tc       (t)
      );

      assign cnt_a[gi] = 13'(c);
      assign ovf_a[gi] = o;
      assign unf_a[gi] = u;
      assign tc_a[gi]  = t;
   end

   // Plain integer arithmetic: limits are 0 and 2^w-1.
   function automatic int mask_of(int w);
      return (1 << w) - 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NCFG; i++) begin
         int mk, c, s, t;
         mk = mask_of(CFG_W[i]);
         c  = m_cnt[i];
         s  = int'(step) & mk;
         if (!rst_n) begin
            m_cnt[i] <= 0; m_ovf[i] <= 0; m_unf[i] <= 0;
         end else if (load) begin
            m_cnt[i] <= int'(load_val) & mk; m_ovf[i] <= 0; m_unf[i] <= 0;
         end else if (!en) begin
            m_ovf[i] <= 0; m_unf[i] <= 0;
         end else if (up) begin
            t = c + s;
            m_unf[i] <= 0;
            if (t > mk) begin
               m_ovf[i] <= 1;
               m_cnt[i] <= sat_mode ? mk : (t - (mk + 1));
            end else begin
               m_ovf[i] <= 0;
               m_cnt[i] <= t;
            end
         end else begin
            m_ovf[i] <= 0;
            if (s > c) begin
               m_unf[i] <= 1;
               m_cnt[i] <= sat_mode ? 0 : (c - s + mk + 1);
            end else begin
               m_unf[i] <= 0;
               m_cnt[i] <= c - s;
            end
         end
      end
   end

   task automatic check(string name, int idx, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cfg%0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < NCFG; i++) begin
         int exp_tc;
         exp_tc = up ? int'(m_cnt[i] == mask_of(CFG_W[i])) : int'(m_cnt[i] == 0);
         check("model_count", i, int'(cnt_a[i]), m_cnt[i]);
         check("model_ovf", i, int'(ovf_a[i]), m_ovf[i]);
         check("model_unf", i, int'(unf_a[i]), m_unf[i]);
         check("model_tc", i, int'(tc_a[i]), exp_tc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset and async mid-cycle reset
      tick();
      tick();
      check("reset_count", 0, int'(cnt_a[0]), 0);
      rst_n = 1'b1;
      load = 1'b1; load_val = 13'd10;
      tick();
      check("load10", 0, int'(cnt_a[0]), 10);
      load = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_count", 0, int'(cnt_a[0]), 0);
      check("async_rst_ovf", 0, int'(ovf_a[0]), 0);
      load = 1'b1; load_val = 13'd12;
      tick();
      check("load_in_reset", 0, int'(cnt_a[0]), 0);
      load = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("idle_after_rst", 0, int'(cnt_a[0]), 0);
      end

      // wrap up
      load = 1'b1; load_val = 13'd29;
      tick();
      load = 1'b0; up = 1'b1; step = 13'd1; sat_mode = 1'b0; en = 1'b1;
      tick();
      check("wrap_30", 0, int'(cnt_a[0]), 30);
      tick();
      check("wrap_31", 0, int'(cnt_a[0]), 31);
      check("wrap_tc", 0, int'(tc_a[0]), 1);
      check("wrap_31_ovf", 0, int'(ovf_a[0]), 0);
      tick();
      check("wrap_0", 0, int'(cnt_a[0]), 0);
      check("wrap_0_ovf", 0, int'(ovf_a[0]), 1);
      tick();
      check("wrap_1", 0, int'(cnt_a[0]), 1);
      check("wrap_1_ovf", 0, int'(ovf_a[0]), 0);

      // saturate down
      load = 1'b1; load_val = 13'd5; en = 1'b0;
      tick();
      load = 1'b0; up = 1'b0; step = 13'd7; sat_mode = 1'b1; en = 1'b1;
      tick();
      check("sat_dn_cnt", 0, int'(cnt_a[0]), 0);
      check("sat_dn_unf", 0, int'(unf_a[0]), 1);
      check("sat_dn_tc", 0, int'(tc_a[0]), 1);
      tick();
      check("sat_dn_cnt2", 0, int'(cnt_a[0]), 0);
      check("sat_dn_unf2", 0, int'(unf_a[0]), 1);
      en = 1'b0;
      tick();
      check("sat_dn_idle_unf", 0, int'(unf_a[0]), 0);

      // load priority over enable
      load = 1'b1; load_val = 13'd18; en = 1'b1; up = 1'b1; step = 13'd3; sat_mode = 1'b0;
      tick();
      check("ld_pri_cnt", 0, int'(cnt_a[0]), 18);
      check("ld_pri_ovf", 0, int'(ovf_a[0]), 0);
      load = 1'b0;
      tick();
      check("ld_pri_next", 0, int'(cnt_a[0]), 21);

      // step of zero in both directions
      step = 13'd0; up = 1'b0;
      tick();
      check("step0_dn", 0, int'(cnt_a[0]), 21);
      check("step0_dn_unf", 0, int'(unf_a[0]), 0);
      up = 1'b1;
      tick();
      check("step0_up", 0, int'(cnt_a[0]), 21);
      check("step0_up_ovf", 0, int'(ovf_a[0]), 0);

      // 9-bit, borrow across group boundaries
      load = 1'b1; load_val = 13'h100; en = 1'b0;
      tick();
      load = 1'b0; up = 1'b0; step = 13'd1; sat_mode = 1'b0; en = 1'b1;
      tick();
      check("w9_0ff", 1, int'(cnt_a[1]), 'h0FF);
      check("w9_0ff_unf", 1, int'(unf_a[1]), 0);
      load = 1'b1; load_val = 13'h0;
      tick();
      load = 1'b0;
      tick();
      check("w9_1ff", 1, int'(cnt_a[1]), 'h1FF);
      check("w9_1ff_unf", 1, int'(unf_a[1]), 1);
      check("w13_1fff", 3, int'(cnt_a[3]), 'h1FFF);

      // random controls, all configurations checked by the model every cycle
      for (int k = 0; k < 10000; k++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         load     = ($urandom_range(0, 9) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up       = 1'($urandom_range(0, 1));
         sat_mode = 1'($urandom_range(0, 1));
         load_val = 13'($urandom);
         step     = ($urandom_range(0, 1) != 0) ? 13'($urandom_range(0, 3)) : 13'($urandom);
         tick();
      end

      rst_n = 1'b1; en = 1'b0; load = 1'b0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
